// File: rtl/piccolo128_sched_if.sv
// Piccolo-128 scheduler bus: requester handshake, datapath control and
// ciphertext output handshake. The slave side is the scheduler itself.
interface piccolo128_sched_if #(
  parameter int RND_W = 5,
  parameter int NR_W  = 4
);
  logic             req0;
  logic             req1;
  logic             ack0;
  logic             ack1;
  logic             core_load;
  logic             core_sel;
  logic             core_step;
  logic [RND_W-1:0] core_rnd;
  logic [NR_W-1:0]  core_nrnd;
  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic             busy;

  modport master (
    output req0, req1, out_ready,
    input  ack0, ack1, core_load, core_sel, core_step, core_rnd, core_nrnd,
           out_valid, out_id, busy
  );

  modport slave (
    input  req0, req1, out_ready,
    output ack0, ack1, core_load, core_sel, core_step, core_rnd, core_nrnd,
           out_valid, out_id, busy
  );
endinterface

// File: rtl/piccolo128_sched.sv
// Round-robin arbiter and round sequencer for the shared Piccolo-128
// iterative datapath. Produces load/step/round controls only; no data path.
//
// state | meaning
// IDLE  | no block in flight, waiting for a request
// RUN   | datapath advancing up to UNROLL rounds per cycle
// DONE  | ciphertext final, held until out_ready (may re-accept same cycle)
module piccolo128_sched #(
  parameter int ROUNDS = 31,
  parameter int UNROLL = 8,
  parameter int RND_W  = 5,
  parameter int NR_W   = 4
) (
  input  logic clk,
  input  logic reset,
  piccolo128_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so rnd + UNROLL never wraps before the compare.
  localparam logic [RND_W:0] ROUNDS_X = (RND_W+1)'(ROUNDS);
  localparam logic [RND_W:0] UNROLL_X = (RND_W+1)'(UNROLL);

  state_t           state, state_nxt;
  logic [RND_W-1:0] rnd, rnd_nxt;
  logic             id, id_nxt;
  logic             rr_ptr, rr_nxt;
  logic [1:0]       req;
  logic             gnt, gnt_vld, accept;
  logic [RND_W:0]   rnd_sum, rnd_left, nrnd_x;

  assign req = {bus.req1, bus.req0};

  // Round-robin grant: favoured requester first, otherwise the other one.
  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    if (req[rr_ptr]) begin
      gnt     = rr_ptr;
      gnt_vld = 1'b1;
    end else if (req[~rr_ptr]) begin
      gnt     = ~rr_ptr;
      gnt_vld = 1'b1;
    end
  end

  // Round bookkeeping: next index and size of the current step.
  always_comb begin
    rnd_sum  = {1'b0, rnd} + UNROLL_X;
    rnd_left = ROUNDS_X - {1'b0, rnd};
    nrnd_x   = (rnd_left < UNROLL_X) ? rnd_left : UNROLL_X;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    rnd_nxt       = rnd;
    id_nxt        = id;
    rr_nxt        = rr_ptr;
    accept        = 1'b0;
    bus.ack0      = 1'b0;
    bus.ack1      = 1'b0;
    bus.core_load = 1'b0;
    bus.core_sel  = 1'b0;
    bus.core_step = 1'b0;
    bus.core_rnd  = '0;
    bus.core_nrnd = '0;
    bus.out_valid = 1'b0;
    bus.out_id    = 1'b0;
    bus.busy      = 1'b0;

    case (state)
      IDLE: accept = gnt_vld;
      RUN: begin
        bus.core_step = 1'b1;
        bus.core_rnd  = rnd;
        bus.core_nrnd = NR_W'(nrnd_x);
        bus.busy      = 1'b1;
        rnd_nxt       = rnd_sum[RND_W-1:0];
        if (rnd_sum >= ROUNDS_X) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_id    = id;
        bus.busy      = 1'b1;
        if (bus.out_ready) begin
          accept = gnt_vld;
          if (!gnt_vld) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs must read zero while reset is held, even with requests up.
    if (reset) accept = 1'b0;

    if (accept) begin
      state_nxt     = RUN;
      rnd_nxt       = '0;
      id_nxt        = gnt;
      rr_nxt        = ~gnt;
      bus.core_load = 1'b1;
      bus.ack0      = ~gnt;
      bus.ack1      = gnt;
    end

    bus.core_sel = gnt & ~reset;
  end

  // State and sequencing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rnd    <= '0;
      id     <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      rnd    <= rnd_nxt;
      id     <= id_nxt;
      rr_ptr <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_piccolo128_sched.sv
// Self-checking bench for piccolo128_sched: directed scenarios plus a
// randomized run checked against a transaction-level scheduler model.
module tb_piccolo128_sched;

  localparam int ROUNDS = 31;
  localparam int U      = 8;
  localparam int NSTEPS = (ROUNDS + U - 1) / U;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  piccolo128_sched_if #(.RND_W(5), .NR_W(4)) bm  ();
  piccolo128_sched_if #(.RND_W(5), .NR_W(4)) b1  ();
  piccolo128_sched_if #(.RND_W(5), .NR_W(5)) b31 ();

  piccolo128_sched #(.ROUNDS(31), .UNROLL(8), .RND_W(5), .NR_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bm.slave)
  );
  piccolo128_sched #(.ROUNDS(31), .UNROLL(1), .RND_W(5), .NR_W(4)) dut_u1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );
  piccolo128_sched #(.ROUNDS(31), .UNROLL(31), .RND_W(5), .NR_W(5)) dut_u31 (
    .clk(clk), .reset(reset), .bus(b31.slave)
  );

  function automatic logic [15:0] obs_main();
    return {bm.ack0, bm.ack1, bm.core_load, bm.core_step, bm.core_rnd,
            bm.core_nrnd, bm.out_valid, bm.out_id, bm.busy};
  endfunction

  function automatic logic [15:0] mk(input logic a0, input logic a1,
                                     input logic ld, input logic st,
                                     input logic [4:0] r, input logic [3:0] n,
                                     input logic ov, input logic oid,
                                     input logic bz);
    return {a0, a1, ld, st, r, n, ov, oid, bz};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bm.req0 = 1'b0;  bm.req1 = 1'b0;  bm.out_ready = 1'b0;
    b1.req0 = 1'b0;  b1.req1 = 1'b0;  b1.out_ready = 1'b0;
    b31.req0 = 1'b0; b31.req1 = 1'b0; b31.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bm.req0 = 1'b1; bm.req1 = 1'b1; bm.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_main() !== 16'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0000", obs_main());
    end
    checks++;
    if (bm.core_sel !== 1'b0) begin
      errors++; $display("FAIL reset_core_sel got %b exp 0", bm.core_sel);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({obs_main(), bm.core_sel} !== 17'h0) begin
      errors++; $display("FAIL idle_outputs got %h exp 0", {obs_main(), bm.core_sel});
    end
    next_cycle();
  endtask

  task automatic test_single();
    int srnd[4] = '{0, 8, 16, 24};
    int snr[4]  = '{8, 8, 8, 7};
    logic [15:0] e;
    pulse_reset();
    bm.req0 = 1'b1; bm.out_ready = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0)      e = mk(1, 0, 1, 0, 0, 0, 0, 0, 0);
      else if (c <= 4) e = mk(0, 0, 0, 1, 5'(srnd[c-1]), 4'(snr[c-1]), 0, 0, 1);
      else if (c == 5) e = mk(0, 0, 0, 0, 0, 0, 1, 0, 1);
      else             e = 16'h0;
      checks++;
      if (obs_main() !== e) begin
        errors++; $display("FAIL single_c%0d got %h exp %h", c, obs_main(), e);
      end
      if (c == 0) begin
        checks++;
        if (bm.core_sel !== 1'b0) begin
          errors++; $display("FAIL single_sel got %b exp 0", bm.core_sel);
        end
      end
      next_cycle();
      if (c == 0) bm.req0 = 1'b0;
    end
  endtask

  task automatic test_contention();
    int   k;
    logic g, pg;
    pulse_reset();
    bm.req0 = 1'b1; bm.req1 = 1'b1; bm.out_ready = 1'b1;
    pg = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c % 5 == 0) begin
        k = c / 5;
        g = (k % 2) == 1;
        checks++;
        if ({bm.ack0, bm.ack1, bm.core_load, bm.core_sel, bm.core_step} !== {~g, g, 1'b1, g, 1'b0}) begin
          errors++;
          $display("FAIL contention_grant c%0d got %b exp %b", c,
                   {bm.ack0, bm.ack1, bm.core_load, bm.core_sel, bm.core_step}, {~g, g, 1'b1, g, 1'b0});
        end
        if (c > 0) begin
          checks++;
          if ({bm.out_valid, bm.out_id} !== {1'b1, pg}) begin
            errors++;
            $display("FAIL contention_outid c%0d got %b exp %b", c, {bm.out_valid, bm.out_id}, {1'b1, pg});
          end
        end
        pg = g;
      end else begin
        checks++;
        if ({bm.ack0, bm.ack1, bm.core_load, bm.core_step, bm.out_valid} !== 5'b00010) begin
          errors++;
          $display("FAIL contention_run c%0d got %b exp 00010", c,
                   {bm.ack0, bm.ack1, bm.core_load, bm.core_step, bm.out_valid});
        end
      end
      next_cycle();
    end
    bm.req0 = 1'b0; bm.req1 = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    checks++;
    if (bm.busy !== 1'b0) begin
      errors++; $display("FAIL contention_drain got %b exp 0", bm.busy);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    bm.req0 = 1'b1; bm.out_ready = 1'b0;
    next_cycle();
    bm.req0 = 1'b0; bm.req1 = 1'b1;
    repeat (4) next_cycle();
    for (int c = 5; c <= 14; c++) begin
      @(negedge clk);
      checks++;
      if ({bm.out_valid, bm.out_id, bm.ack1, bm.core_load, bm.core_step, bm.busy} !== 6'b100001) begin
        errors++;
        $display("FAIL backpressure_hold c%0d got %b exp 100001", c,
                 {bm.out_valid, bm.out_id, bm.ack1, bm.core_load, bm.core_step, bm.busy});
      end
      next_cycle();
    end
    bm.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bm.ack1, bm.ack0, bm.core_load, bm.core_sel, bm.out_valid, bm.out_id} !== 6'b101110) begin
      errors++;
      $display("FAIL backpressure_release got %b exp 101110",
               {bm.ack1, bm.ack0, bm.core_load, bm.core_sel, bm.out_valid, bm.out_id});
    end
    next_cycle();
    bm.req1 = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    checks++;
    if ({bm.out_valid, bm.out_id} !== 2'b11) begin
      errors++; $display("FAIL backpressure_second got %b exp 11", {bm.out_valid, bm.out_id});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    bm.req0 = 1'b1; bm.out_ready = 1'b1;
    next_cycle();
    bm.req0 = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bm.core_rnd !== 5'd8) begin
      errors++; $display("FAIL resetmid_rnd got %0d exp 8", bm.core_rnd);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({obs_main(), bm.core_sel} !== 17'h0) begin
      errors++; $display("FAIL resetmid_outputs got %h exp 0", {obs_main(), bm.core_sel});
    end
    checks++;
    if (dut.rr_ptr !== 1'b0) begin
      errors++; $display("FAIL resetmid_rr got %b exp 0", dut.rr_ptr);
    end
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({bm.out_valid, bm.busy, bm.core_step} !== 3'b000) begin
        errors++;
        $display("FAIL resetmid_discard c%0d got %b exp 000", c, {bm.out_valid, bm.busy, bm.core_step});
      end
      next_cycle();
    end
    bm.req1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({bm.ack0, bm.ack1, bm.core_load, bm.core_sel} !== 4'b0111) begin
      errors++;
      $display("FAIL resetmid_regrant got %b exp 0111", {bm.ack0, bm.ack1, bm.core_load, bm.core_sel});
    end
    next_cycle();
    bm.req1 = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    checks++;
    if ({bm.out_valid, bm.out_id} !== 2'b11) begin
      errors++; $display("FAIL resetmid_done got %b exp 11", {bm.out_valid, bm.out_id});
    end
    next_cycle();
  endtask

  task automatic test_sweep_u1();
    pulse_reset();
    b1.req0 = 1'b1; b1.out_ready = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      checks++;
      if (c == 0) begin
        if ({b1.ack0, b1.core_load, b1.core_step} !== 3'b110) begin
          errors++; $display("FAIL u1_accept got %b exp 110", {b1.ack0, b1.core_load, b1.core_step});
        end
      end else if (c <= 31) begin
        if ({b1.core_step, b1.core_rnd, b1.core_nrnd, b1.out_valid} !== {1'b1, 5'(c-1), 4'd1, 1'b0}) begin
          errors++;
          $display("FAIL u1_step c%0d got %b exp %b", c, {b1.core_step, b1.core_rnd, b1.core_nrnd, b1.out_valid},
                   {1'b1, 5'(c-1), 4'd1, 1'b0});
        end
      end else if (c == 32) begin
        if ({b1.out_valid, b1.out_id, b1.core_step} !== 3'b100) begin
          errors++; $display("FAIL u1_done got %b exp 100", {b1.out_valid, b1.out_id, b1.core_step});
        end
      end else begin
        if (b1.busy !== 1'b0) begin
          errors++; $display("FAIL u1_idle got %b exp 0", b1.busy);
        end
      end
      next_cycle();
      if (c == 0) b1.req0 = 1'b0;
    end
  endtask

  task automatic test_sweep_u31();
    pulse_reset();
    b31.req0 = 1'b1; b31.out_ready = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      case (c)
        0: if ({b31.ack0, b31.core_load, b31.core_step} !== 3'b110) begin
             errors++; $display("FAIL u31_accept got %b exp 110", {b31.ack0, b31.core_load, b31.core_step});
           end
        1: if ({b31.core_step, b31.core_rnd, b31.core_nrnd, b31.out_valid} !== {1'b1, 5'd0, 5'd31, 1'b0}) begin
             errors++;
             $display("FAIL u31_step got %b exp %b", {b31.core_step, b31.core_rnd, b31.core_nrnd, b31.out_valid},
                      {1'b1, 5'd0, 5'd31, 1'b0});
           end
        2: if ({b31.out_valid, b31.core_step} !== 2'b10) begin
             errors++; $display("FAIL u31_done got %b exp 10", {b31.out_valid, b31.core_step});
           end
        default: if (b31.busy !== 1'b0) begin
             errors++; $display("FAIL u31_idle got %b exp 0", b31.busy);
           end
      endcase
      next_cycle();
      if (c == 0) b31.req0 = 1'b0;
    end
  endtask

  // Transaction-level model: a job is accepted, takes NSTEPS steps of U
  // rounds (last one shortened), then waits for out_ready.
  task automatic test_random();
    int          m_busy, m_age, m_rr;
    logic        m_id, g, gv, acc, in_run, in_done, drain, a0, a1;
    logic [1:0]  rq;
    int          e_rnd, e_nrnd;
    logic [15:0] e;
    m_busy = 0; m_age = 0; m_rr = 0; m_id = 1'b0;
    pulse_reset();
    for (int c = 0; c < 700; c++) begin
      drain = (c >= 500);
      if (!drain) begin
        if (!bm.req0 && $urandom_range(0, 2) == 0) bm.req0 = 1'b1;
        if (!bm.req1 && $urandom_range(0, 2) == 0) bm.req1 = 1'b1;
        bm.out_ready = 1'($urandom_range(0, 1));
      end else begin
        bm.out_ready = 1'b1;
      end
      @(negedge clk);
      in_run  = (m_busy != 0) && (m_age < NSTEPS);
      in_done = (m_busy != 0) && (m_age == NSTEPS);
      rq = {bm.req1, bm.req0};
      gv = 1'b0; g = 1'b0;
      if (rq[m_rr]) begin
        gv = 1'b1; g = 1'(m_rr);
      end else if (rq[1-m_rr]) begin
        gv = 1'b1; g = 1'(1 - m_rr);
      end
      acc = gv && ((m_busy == 0) || (in_done && bm.out_ready));
      e_rnd  = m_age * U;
      e_nrnd = (ROUNDS - e_rnd < U) ? ROUNDS - e_rnd : U;
      e = mk(acc && !g, acc && g, acc, in_run,
             in_run ? 5'(e_rnd) : 5'd0, in_run ? 4'(e_nrnd) : 4'd0,
             in_done, in_done && m_id, m_busy != 0);
      checks++;
      if (obs_main() !== e) begin
        errors++; $display("FAIL random_c%0d got %h exp %h", c, obs_main(), e);
      end
      if (acc) begin
        checks++;
        if (bm.core_sel !== g) begin
          errors++; $display("FAIL random_sel_c%0d got %b exp %b", c, bm.core_sel, g);
        end
      end
      a0 = bm.ack0;
      a1 = bm.ack1;
      if (acc) begin
        m_busy = 1; m_age = 0; m_id = g; m_rr = g ? 0 : 1;
      end else if (in_run) begin
        m_age++;
      end else if (in_done && bm.out_ready) begin
        m_busy = 0;
      end
      next_cycle();
      if (a0) bm.req0 = 1'b0;
      if (a1) bm.req1 = 1'b0;
      if (drain && m_busy == 0 && !bm.req0 && !bm.req1) break;
    end
    @(negedge clk);
    checks++;
    if ({bm.busy, bm.req0, bm.req1} !== 3'b000) begin
      errors++; $display("FAIL random_drain got %b exp 000", {bm.busy, bm.req0, bm.req1});
    end
    next_cycle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2 reset = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_sweep_u1();
    test_sweep_u31();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
